calc_sequencer: RTL and testbench

- Top-level controller for the calculator datapath.
- Enables and clears the operand-entry block, then captures num1/num2 when entry reports done.
- Lets the user pick an operator with the buttons, runs the chosen operation on an internal shared iterative add/shift unit, and holds the result for the display logic.
- Sits between the operand-entry block and the OLED/7-seg display drivers, in the freq625m domain.

---
 rtl/calc_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator control FSM with a shared iterative add/shift unit.
// Captures operands from the entry block, lets the user pick an operator,
// runs add/sub in one cycle and mul/div one bit per cycle, then holds the result.
module calc_sequencer #(
    parameter int unsigned W     = 18,
    parameter int unsigned CNT_W = 5
) (
    input  logic            freq625m,
    input  logic            rst_n,
    input  logic            btnC,
    input  logic            btnU,
    input  logic            btnD,
    input  logic [W-1:0]    num1,
    input  logic [W-1:0]    num2,
    input  logic            done,
    output logic            entry_en,
    output logic            entry_clr,
    output logic [1:0]      op_sel,
    output logic            busy,
    output logic            result_valid,
    output logic [2*W-1:0]  result,
    output logic            neg,
    output logic            div_zero,
    output logic [W-1:0]    remainder
);

    localparam int unsigned RW = 2 * W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'b00,
        ST_OPSEL = 2'b01,
        ST_EXEC  = 2'b10,
        ST_SHOW  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic btnc_q, btnu_q, btnd_q, done_q;
    logic c_edge, u_edge, d_edge, done_edge;

    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [RW-1:0]    acc_q, acc_d, x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       op_sel_d;
    logic             entry_en_d, entry_clr_d, busy_d, result_valid_d;
    logic [RW-1:0]    result_d;
    logic             neg_d, div_zero_d;
    logic [W-1:0]     remainder_d;

    logic             iter_last, exec_done;
    logic [RW-1:0]    add_sum, mul_sum;
    logic [W-1:0]     diff_ab, diff_ba;
    logic [W:0]       rem_shift, rem_trial, div_rem_next;
    logic [W-1:0]     div_quo_next;

    // Rising-edge detection; btnC wins over btnU, btnU over btnD
    assign c_edge    = btnC & ~btnc_q;
    assign u_edge    = btnU & ~btnu_q & ~c_edge;
    assign d_edge    = btnD & ~btnd_q & ~c_edge & ~u_edge;
    assign done_edge = done & ~done_q;

    // Shared arithmetic: single-cycle add/sub and one step of mul/div
    assign add_sum      = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
    assign diff_ab      = a_q - b_q;
    assign diff_ba      = b_q - a_q;
    assign mul_sum      = acc_q + (y_q[0] ? x_q : {RW{1'b0}});
    assign rem_shift    = {acc_q[W-1:0], y_q[W-1]};
    assign rem_trial    = rem_shift - {1'b0, b_q};
    assign div_rem_next = rem_trial[W] ? rem_shift : rem_trial;
    assign div_quo_next = {y_q[W-2:0], ~rem_trial[W]};

    // Last EXEC cycle: immediately for add/sub/div-by-zero, else after W steps
    assign iter_last = (cnt_q == CNT_W'(W - 1));
    assign exec_done = (op_sel == OP_ADD) || (op_sel == OP_SUB) ||
                       ((op_sel == OP_DIV) && (b_q == '0)) || iter_last;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge freq625m) begin
        if (!rst_n) begin
            state_q      <= ST_ENTRY;
            btnc_q       <= 1'b0;
            btnu_q       <= 1'b0;
            btnd_q       <= 1'b0;
            done_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            op_sel       <= OP_ADD;
            entry_en     <= 1'b1;
            entry_clr    <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            neg          <= 1'b0;
            div_zero     <= 1'b0;
            remainder    <= '0;
        end else begin
            state_q      <= state_d;
            btnc_q       <= btnC;
            btnu_q       <= btnU;
            btnd_q       <= btnD;
            done_q       <= done;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            op_sel       <= op_sel_d;
            entry_en     <= entry_en_d;
            entry_clr    <= entry_clr_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;
            result       <= result_d;
            neg          <= neg_d;
            div_zero     <= div_zero_d;
            remainder    <= remainder_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTRY: if (done_edge) state_d = ST_OPSEL;
            ST_OPSEL: if (c_edge)    state_d = ST_EXEC;
            ST_EXEC:  if (exec_done) state_d = ST_SHOW;
            ST_SHOW:  if (c_edge)    state_d = ST_ENTRY;
            default:                 state_d = ST_ENTRY;
        endcase
    end

    // Next values of outputs and datapath registers
    always_comb begin
        a_d            = a_q;
        b_d            = b_q;
        acc_d          = acc_q;
        x_d            = x_q;
        y_d            = y_q;
        cnt_d          = cnt_q;
        op_sel_d       = op_sel;
        result_d       = result;
        neg_d          = neg;
        div_zero_d     = div_zero;
        remainder_d    = remainder;
        entry_clr_d    = 1'b0;
        entry_en_d     = (state_d == ST_ENTRY);
        busy_d         = (state_d == ST_EXEC);
        result_valid_d = (state_d == ST_SHOW);

        case (state_q)
            ST_ENTRY: begin
                if (done_edge) begin
                    a_d = num1;
                    b_d = num2;
                end
            end
            ST_OPSEL: begin
                if (c_edge) begin
                    // Prime the iterative unit: x = multiplicand, y = multiplier or dividend
                    acc_d = '0;
                    x_d   = {{W{1'b0}}, a_q};
                    y_d   = (op_sel == OP_DIV) ? a_q : b_q;
                    cnt_d = '0;
                end else if (u_edge) begin
                    op_sel_d = op_sel + 2'd1;
                end else if (d_edge) begin
                    op_sel_d = op_sel - 2'd1;
                end
            end
            ST_EXEC: begin
                case (op_sel)
                    OP_ADD: begin
                        result_d = add_sum;
                        neg_d    = 1'b0;
                    end
                    OP_SUB: begin
                        if (a_q >= b_q) begin
                            result_d = {{W{1'b0}}, diff_ab};
                            neg_d    = 1'b0;
                        end else begin
                            result_d = {{W{1'b0}}, diff_ba};
                            neg_d    = 1'b1;
                        end
                    end
                    OP_MUL: begin
                        acc_d = mul_sum;
                        x_d   = x_q << 1;
                        y_d   = y_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (iter_last) begin
                            result_d = mul_sum;
                            neg_d    = 1'b0;
                        end
                    end
                    OP_DIV: begin
                        if (b_q == '0) begin
                            div_zero_d  = 1'b1;
                            result_d    = '0;
                            remainder_d = '0;
                            neg_d       = 1'b0;
                        end else begin
                            acc_d = {{(RW - W - 1){1'b0}}, div_rem_next};
                            y_d   = div_quo_next;
                            cnt_d = cnt_q + CNT_W'(1);
                            if (iter_last) begin
                                result_d    = {{W{1'b0}}, div_quo_next};
                                remainder_d = div_rem_next[W-1:0];
                                neg_d       = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            ST_SHOW: begin
                if (c_edge) begin
                    entry_clr_d = 1'b1;
                    result_d    = '0;
                    neg_d       = 1'b0;
                    div_zero_d  = 1'b0;
                    remainder_d = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer with a behavioural model.
module tb_calc_sequencer;

    localparam int unsigned W = 18;

    logic            freq625m = 1'b0;
    logic            rst_n = 1'b0;
    logic            btnC = 1'b0, btnU = 1'b0, btnD = 1'b0;
    logic [W-1:0]    num1 = '0, num2 = '0;
    logic            done = 1'b0;
    logic            entry_en, entry_clr, busy, result_valid, neg, div_zero;
    logic [1:0]      op_sel;
    logic [2*W-1:0]  result;
    logic [W-1:0]    remainder;

    calc_sequencer #(.W(W), .CNT_W(5)) dut (
        .freq625m(freq625m), .rst_n(rst_n),
        .btnC(btnC), .btnU(btnU), .btnD(btnD),
        .num1(num1), .num2(num2), .done(done),
        .entry_en(entry_en), .entry_clr(entry_clr), .op_sel(op_sel),
        .busy(busy), .result_valid(result_valid), .result(result),
        .neg(neg), .div_zero(div_zero), .remainder(remainder)
    );

    always #80 freq625m = ~freq625m;

    typedef struct {
        longint unsigned res;
        longint unsigned rem;
        bit              neg;
        bit              dz;
        int              due;
        int              busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    longint unsigned a_m, b_m;
    int              op_m = 0;

    always @(posedge freq625m) cyc++;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every result_valid rising edge against the scoreboard
    int   busy_cnt = 0;
    bit   rv_prev = 1'b0;
    exp_t mon_e;
    always @(negedge freq625m) begin
        if (!rst_n) begin
            busy_cnt = 0;
            rv_prev  = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            check("flag_exclusive", longint'(neg & div_zero), 0);
            if (result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", longint'(result), mon_e.res);
                    check("remainder", longint'(remainder), mon_e.rem);
                    check("neg", longint'(neg), longint'(mon_e.neg));
                    check("div_zero", longint'(div_zero), longint'(mon_e.dz));
                    check("latency", longint'(cyc), longint'(mon_e.due));
                    check("busy_cycles", longint'(busy_cnt), longint'(mon_e.busy_cycles));
                end
                busy_cnt = 0;
            end
            rv_prev = result_valid;
        end
    end

    task automatic tick();
        @(posedge freq625m);
        #1;
    endtask

    // Reference model computed directly from the operator definitions
    function automatic exp_t model(input longint unsigned a, input longint unsigned b, input int op);
        exp_t e;
        e.res = 0; e.rem = 0; e.neg = 0; e.dz = 0; e.due = 0; e.busy_cycles = 0;
        case (op)
            0: e.res = a + b;
            1: if (a >= b) e.res = a - b; else begin e.res = b - a; e.neg = 1; end
            2: e.res = a * b;
            default: if (b == 0) e.dz = 1; else begin e.res = a / b; e.rem = a % b; end
        endcase
        return e;
    endfunction

    task automatic enter(input longint unsigned a, input longint unsigned b);
        a_m  = a;
        b_m  = b;
        num1 = W'(a);
        num2 = W'(b);
        done = 1'b1;
        tick();
        check("entry_en_low_in_opsel", longint'(entry_en), 0);
        done = 1'b0;
        tick();
    endtask

    task automatic press(input bit up);
        if (up) btnU = 1'b1; else btnD = 1'b1;
        tick();
        btnU = 1'b0;
        btnD = 1'b0;
        tick();
        op_m = up ? (op_m + 1) % 4 : (op_m + 3) % 4;
    endtask

    task automatic set_op(input int target);
        bit up;
        up = 1'($urandom_range(0, 1));
        while (op_m != target) press(up);
        check("op_sel_select", longint'(op_sel), longint'(op_m));
    endtask

    // Confirm the operator and wait for the result; expectation goes to the scoreboard
    task automatic run_op(input bit with_u, input bit disturb);
        exp_t e;
        int   lat;
        bit   seen;
        e   = model(a_m, b_m, op_m);
        lat = (op_m == 2 || (op_m == 3 && b_m != 0)) ? W + 1 : 2;
        e.due = cyc + lat;
        e.busy_cycles = lat - 1;
        exp_q.push_back(e);
        btnC = 1'b1;
        if (with_u) btnU = 1'b1;
        tick();
        btnC = 1'b0;
        btnU = 1'b0;
        if (disturb) begin
            btnU = 1'b1; btnC = 1'b1; tick();
            btnU = 1'b0; btnC = 1'b0; tick();
            btnD = 1'b1; tick();
            btnD = 1'b0; tick();
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (result_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("result_valid_timeout", longint'(seen), 1);
        check("op_sel_frozen", longint'(op_sel), longint'(op_m));
    endtask

    task automatic finish_show();
        btnC = 1'b1;
        tick();
        check("show_exit_entry_clr", longint'(entry_clr), 1);
        check("show_exit_result_valid", longint'(result_valid), 0);
        check("show_exit_result", longint'(result), 0);
        check("show_exit_entry_en", longint'(entry_en), 1);
        btnC = 1'b0;
        tick();
        check("entry_clr_one_cycle", longint'(entry_clr), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset for three cycles, then release
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_entry_clr", longint'(entry_clr), 1);
        check("rst_entry_en", longint'(entry_en), 1);
        check("rst_op_sel", longint'(op_sel), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_result_valid", longint'(result_valid), 0);
        check("rst_result", longint'(result), 0);
        check("rst_flags", longint'({neg, div_zero}), 0);
        check("rst_remainder", longint'(remainder), 0);
        tick();
        check("rst_entry_clr_drop", longint'(entry_clr), 0);
        check("rst_entry_en_hold", longint'(entry_en), 1);

        // Add, with btnU held alongside btnC (confirm wins)
        enter(150000, 200000);
        run_op(1'b1, 1'b0);
        finish_show();

        // Sub with negative result
        enter(5, 12);
        press(1'b1);
        check("op_up_to_sub", longint'(op_sel), 1);
        run_op(1'b0, 1'b0);
        finish_show();

        // Wrap checks, then div
        enter(100000, 7);
        press(1'b1); press(1'b1); press(1'b1);
        check("op_wrap_up", longint'(op_sel), 0);
        press(1'b0);
        check("op_wrap_down", longint'(op_sel), 3);
        run_op(1'b0, 1'b0);
        // done held high across the return to ENTRY must not capture again
        done = 1'b1;
        tick();
        finish_show();
        tick();
        check("done_held_ignored", longint'(entry_en), 1);
        tick();
        check("done_held_ignored2", longint'(entry_en), 1);
        done = 1'b0;
        tick();

        // Division by zero
        enter(100000, 0);
        check("op_retained", longint'(op_sel), 3);
        run_op(1'b0, 1'b0);
        finish_show();

        // Full-scale mul with buttons pulsed during EXEC
        enter(262143, 262143);
        set_op(2);
        run_op(1'b0, 1'b1);
        finish_show();

        // Reset in the middle of a multiply
        enter(1234, 5678);
        set_op(2);
        btnC = 1'b1;
        tick();
        btnC = 1'b0;
        repeat (8) tick();
        check("mid_busy", longint'(busy), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_result_valid", longint'(result_valid), 0);
        check("mid_rst_result", longint'(result), 0);
        check("mid_rst_entry_en", longint'(entry_en), 1);
        check("mid_rst_entry_clr", longint'(entry_clr), 1);
        check("mid_rst_op_sel", longint'(op_sel), 0);
        rst_n = 1'b1;
        op_m = 0;
        tick();

        // Randomized transactions
        for (int n = 0; n < 16; n++) begin
            longint unsigned a, b;
            int sel;
            a   = longint'($urandom_range(0, (1 << W) - 1));
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      b = 0;
            else if (sel == 1) b = longint'($urandom_range(1, 15));
            else               b = longint'($urandom_range(0, (1 << W) - 1));
            enter(a, b);
            set_op(int'($urandom_range(0, 3)));
            run_op(1'b0, 1'b0);
            finish_show();
        end

        repeat (3) tick();
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
